// File: rtl/led_scan_capture_if.sv
// rtl/led_scan_capture_if.sv - LED matrix scan pins plus published-frame read port
interface led_scan_capture_if;
    logic [2:0] LED_COM;
    logic [0:7] LED_Red;
    logic [0:7] LED_Green;
    logic [0:7] LED_Blue;
    logic       LED_en;
    logic [2:0] rd_row;
    logic [0:7] rd_red;
    logic [0:7] rd_green;
    logic [0:7] rd_blue;
    logic       frame_valid;
    logic       scan_stall;
    logic       seq_err;

    modport master (
        output LED_COM, LED_Red, LED_Green, LED_Blue, LED_en, rd_row,
        input  rd_red, rd_green, rd_blue, frame_valid, scan_stall, seq_err
    );

    modport slave (
        input  LED_COM, LED_Red, LED_Green, LED_Blue, LED_en, rd_row,
        output rd_red, rd_green, rd_blue, frame_valid, scan_stall, seq_err
    );
endinterface

// File: rtl/led_scan_capture.sv
// rtl/led_scan_capture.sv - rebuilds 8x8 RGB frames from a row-multiplexed LED scan
// Optional row-order checking is enabled by defining LED_SCAN_SEQ_CHECK_EN.
module led_scan_capture #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int ACTIVE_LOW_DATA = 0
) (
    input logic               clk,
    input logic               reset,
    led_scan_capture_if.slave bus
);
    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] DWELL_MAX   = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0] DATA_XOR    = (ACTIVE_LOW_DATA != 0) ? 24'hFF_FFFF : 24'h00_0000;

    // Rows are kept packed as {red, green, blue}.
    logic [2:0]  com_s1_q;
    logic [23:0] data_s1_q;
    logic        en_s1_q;
    logic [2:0]  prev_com_q;

    logic [7:0]  settle_q, settle_d;
    logic [23:0] dwell_q, dwell_d;
    logic [7:0]  seen_q, seen_d;
    logic        stall_q, stall_d;
    logic        fv_q, fv_d;

    logic [23:0] shadow_q [8];
    logic [23:0] pub_q    [8];
    logic [23:0] rd_q;

    logic        com_change;
    logic        capture;
    logic        publish;
    logic        seq_bad;
    logic [7:0]  row_bit;
    logic [7:0]  seen_new;
    logic [23:0] cap_data;

`ifdef LED_SCAN_SEQ_CHECK_EN
    logic seq_err_q;
`endif

    always_comb begin
        com_change = (com_s1_q != prev_com_q);
        row_bit    = 8'b1 << com_s1_q;
        seen_new   = seen_q | row_bit;
        cap_data   = data_s1_q ^ DATA_XOR;
        capture    = !com_change && en_s1_q && (settle_q == SETTLE_LAST);
        publish    = capture && (seen_new == 8'hFF);

`ifdef LED_SCAN_SEQ_CHECK_EN
        seq_bad = com_change && en_s1_q && (com_s1_q != prev_com_q + 3'd1);
`else
        seq_bad = 1'b0;
`endif

        settle_d = settle_q;
        if (com_change || !en_s1_q) begin
            settle_d = 8'd0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 8'd1;
        end

        dwell_d = dwell_q;
        if (com_change) begin
            dwell_d = 24'd0;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + 24'd1;
        end

        stall_d = stall_q;
        if (com_change) begin
            stall_d = 1'b0;
        end else if (dwell_d == DWELL_MAX) begin
            stall_d = 1'b1;
        end

        // A stall or an ordering error throws away the partial frame.
        seen_d = seen_q;
        if (capture) begin
            seen_d = publish ? 8'h00 : seen_new;
        end
        if ((stall_d && !stall_q) || seq_bad) begin
            seen_d = 8'h00;
        end

        fv_d = publish;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            com_s1_q   <= 3'd0;
            data_s1_q  <= 24'd0;
            en_s1_q    <= 1'b0;
            prev_com_q <= 3'd0;
            settle_q   <= 8'd0;
            dwell_q    <= 24'd0;
            seen_q     <= 8'd0;
            stall_q    <= 1'b0;
            fv_q       <= 1'b0;
            rd_q       <= 24'd0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 24'd0;
                pub_q[i]    <= 24'd0;
            end
        end else begin
            com_s1_q   <= bus.LED_COM;
            data_s1_q  <= {bus.LED_Red, bus.LED_Green, bus.LED_Blue};
            en_s1_q    <= bus.LED_en;
            prev_com_q <= com_s1_q;
            settle_q   <= settle_d;
            dwell_q    <= dwell_d;
            seen_q     <= seen_d;
            stall_q    <= stall_d;
            fv_q       <= fv_d;
            if (capture) begin
                shadow_q[com_s1_q] <= cap_data;
            end
            // The row captured this cycle is not in shadow_q yet, so bypass it in.
            if (publish) begin
                for (int i = 0; i < 8; i++) begin
                    pub_q[i] <= (3'(i) == com_s1_q) ? cap_data : shadow_q[i];
                end
            end
            rd_q <= pub_q[bus.rd_row];
        end
    end

`ifdef LED_SCAN_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_err_q <= 1'b0;
        end else if (seq_bad) begin
            seq_err_q <= 1'b1;
        end
    end
    assign bus.seq_err = seq_err_q;
`else
    assign bus.seq_err = 1'b0;
`endif

    assign bus.rd_red      = rd_q[23:16];
    assign bus.rd_green    = rd_q[15:8];
    assign bus.rd_blue     = rd_q[7:0];
    assign bus.frame_valid = fv_q;
    assign bus.scan_stall  = stall_q;
endmodule

// File: tb/tb_led_scan_capture.sv
// tb/tb_led_scan_capture.sv - directed self-checking bench for led_scan_capture
module tb_led_scan_capture;
    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_scan_capture_if if_a();
    led_scan_capture_if if_b();

    assign if_b.LED_COM   = if_a.LED_COM;
    assign if_b.LED_Red   = if_a.LED_Red;
    assign if_b.LED_Green = if_a.LED_Green;
    assign if_b.LED_Blue  = if_a.LED_Blue;
    assign if_b.LED_en    = if_a.LED_en;
    assign if_b.rd_row    = if_a.rd_row;

    led_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .ACTIVE_LOW_DATA(0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    led_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .ACTIVE_LOW_DATA(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int fv_cnt = 0;
    int fv_at  = -1;
    int c0;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (if_a.frame_valid === 1'b1) begin
            fv_cnt <= fv_cnt + 1;
            fv_at  <= ncyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pins(input logic [2:0] com, input logic [23:0] rgb);
        if_a.LED_COM   = com;
        if_a.LED_Red   = rgb[23:16];
        if_a.LED_Green = rgb[15:8];
        if_a.LED_Blue  = rgb[7:0];
        if_a.LED_en    = 1'b1;
    endtask

    task automatic row(input int com, input logic [23:0] rgb, input int n);
        set_pins(3'(com), rgb);
        tick(n);
    endtask

    task automatic read_row(input string tag, input int r, input logic [23:0] exp_a, input logic [23:0] exp_b);
        if_a.rd_row = 3'(r);
        tick(1);
        check({tag, "_a"}, {8'h0, if_a.rd_red, if_a.rd_green, if_a.rd_blue}, {8'h0, exp_a});
        check({tag, "_b"}, {8'h0, if_b.rd_red, if_b.rd_green, if_b.rd_blue}, {8'h0, exp_b});
    endtask

    function automatic logic [23:0] norm_rgb(input int r);
        logic [7:0] one;
        one = 8'd1;
        return {one << r, 8'h00, 8'hFF};
    endfunction

    function automatic logic [23:0] gl_rgb(input int r);
        return {8'h30 | 8'(r), 8'hC0 | 8'(r), 8'h0F};
    endfunction

    function automatic logic [23:0] z_rgb(input int r);
        return {8'h50 | 8'(r), 8'h0A, 8'hA0 | 8'(r)};
    endfunction

    function automatic logic [23:0] s_rgb(input int r);
        return {8'hA0 | 8'(r), 8'(r), 8'h55};
    endfunction

    initial begin
        reset = 1'b0;
        if_a.rd_row = 3'd0;
        repeat (3) begin
            if_a.LED_COM   = 3'($urandom);
            if_a.LED_Red   = 8'($urandom);
            if_a.LED_Green = 8'($urandom);
            if_a.LED_Blue  = 8'($urandom);
            if_a.LED_en    = 1'($urandom);
            if_a.rd_row    = 3'($urandom);
            tick(1);
        end
        check("rst_rd_a", {8'h0, if_a.rd_red, if_a.rd_green, if_a.rd_blue}, 32'h0);
        check("rst_rd_b", {8'h0, if_b.rd_red, if_b.rd_green, if_b.rd_blue}, 32'h0);
        check("rst_fv", {31'h0, if_a.frame_valid}, 32'h0);
        check("rst_stall", {31'h0, if_a.scan_stall}, 32'h0);
        check("rst_seq", {31'h0, if_a.seq_err}, 32'h0);

        set_pins(3'd0, 24'h0);
        if_a.LED_en = 1'b0;
        reset = 1'b1;
        tick(3);

        // Normal frame, publish latency measured from row 7 on the pins
        for (int r = 0; r < 7; r++) row(r, norm_rgb(r), 10);
        set_pins(3'd7, norm_rgb(7));
        c0 = ncyc;
        tick(10);
        check("norm_fv_cnt", 32'(fv_cnt), 32'd1);
        check("norm_fv_lat", 32'(fv_at), 32'(c0 + SETTLE + 3));
        for (int r = 0; r < 8; r++) read_row("norm_row", r, norm_rgb(r), ~norm_rgb(r));

        // Glitch on row 3: held only 2 cycles, so the frame stays incomplete
        for (int r = 0; r < 3; r++) row(r, gl_rgb(r), 10);
        row(3, 24'hEEEEEE, 2);
        for (int r = 4; r < 8; r++) row(r, gl_rgb(r), 10);
        check("glitch_no_fv", 32'(fv_cnt), 32'd1);
        for (int r = 0; r < 4; r++) row(r, z_rgb(r), 10);
        check("glitch_fv", 32'(fv_cnt), 32'd2);
        read_row("glitch_r3", 3, z_rgb(3), ~z_rgb(3));
        read_row("glitch_r4", 4, gl_rgb(4), ~gl_rgb(4));
        read_row("glitch_r0", 0, z_rgb(0), ~z_rgb(0));

        // Stall at row 5
        row(4, s_rgb(4), 10);
        set_pins(3'd5, s_rgb(5));
        tick(101);
        check("stall_pre", {31'h0, if_a.scan_stall}, 32'h0);
        tick(1);
        check("stall_set", {31'h0, if_a.scan_stall}, 32'h1);
        read_row("stall_keep", 4, gl_rgb(4), ~gl_rgb(4));
        check("stall_fv", 32'(fv_cnt), 32'd2);
        set_pins(3'd6, s_rgb(6));
        tick(1);
        check("stall_hold", {31'h0, if_a.scan_stall}, 32'h1);
        tick(1);
        check("stall_clr", {31'h0, if_a.scan_stall}, 32'h0);
        tick(8);
        row(7, s_rgb(7), 10);
        for (int r = 0; r < 5; r++) row(r, s_rgb(r), 10);
        check("resume_no_fv", 32'(fv_cnt), 32'd2);
        row(5, s_rgb(5), 10);
        check("resume_fv", 32'(fv_cnt), 32'd3);
        read_row("resume_r5", 5, s_rgb(5), ~s_rgb(5));
        read_row("resume_r6", 6, s_rgb(6), ~s_rgb(6));

        // All-zero pins, reading row 7 across the publish edge
        if_a.rd_row = 3'd7;
        row(6, 24'h0, 10);
        row(7, 24'h0, 10);
        for (int r = 0; r < 5; r++) row(r, 24'h0, 10);
        set_pins(3'd5, 24'h0);
        tick(6);
        check("coll_fv", {31'h0, if_a.frame_valid}, 32'h1);
        check("coll_old_a", {8'h0, if_a.rd_red, if_a.rd_green, if_a.rd_blue}, {8'h0, s_rgb(7)});
        check("coll_old_b", {8'h0, if_b.rd_red, if_b.rd_green, if_b.rd_blue}, {8'h0, ~s_rgb(7)});
        tick(1);
        check("coll_new_a", {8'h0, if_a.rd_red, if_a.rd_green, if_a.rd_blue}, 32'h0);
        check("coll_new_b", {8'h0, if_b.rd_red, if_b.rd_green, if_b.rd_blue}, 32'h00FFFFFF);
        tick(3);
        check("coll_fv_cnt", 32'(fv_cnt), 32'd4);
        read_row("low_r2", 2, 24'h0, 24'hFFFFFF);

        // Out-of-order scan 0,1,2,5
        row(6, 24'h0, 10);
        row(7, 24'h0, 10);
        row(0, 24'h0, 10);
        row(1, 24'h0, 10);
        row(2, 24'h0, 10);
        row(5, 24'h0, 10);
`ifdef LED_SCAN_SEQ_CHECK_EN
        check("seq_err", {31'h0, if_a.seq_err}, 32'h1);
`else
        check("seq_err", {31'h0, if_a.seq_err}, 32'h0);
`endif
        row(3, 24'h0, 10);
        row(4, 24'h0, 10);
`ifdef LED_SCAN_SEQ_CHECK_EN
        check("seq_fv", 32'(fv_cnt), 32'd4);
`else
        check("seq_fv", 32'(fv_cnt), 32'd5);
`endif
        for (int r = 5; r < 8; r++) row(r, 24'h0, 10);
        for (int r = 0; r < 3; r++) row(r, 24'h0, 10);
        check("seq_full_fv", 32'(fv_cnt), 32'd5);

        // Reset in the middle of a dwell
        row(3, 24'h0, 10);
        set_pins(3'd4, 24'h0);
        tick(3);
        reset = 1'b0;
        tick(1);
        check("mid_rst_rd", {8'h0, if_a.rd_red, if_a.rd_green, if_a.rd_blue}, 32'h0);
        reset = 1'b1;
        set_pins(3'd0, 24'h0);
        if_a.LED_en = 1'b0;
        tick(15);
        check("mid_rst_fv", 32'(fv_cnt), 32'd5);
        check("mid_rst_seq", {31'h0, if_a.seq_err}, 32'h0);
        check("mid_rst_stall", {31'h0, if_a.scan_stall}, 32'h0);
        read_row("mid_rst_r7", 7, 24'h0, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
